// File: rtl/slave_transmit.sv
// Serial nonce transmitter: queues 32-bit nonces in a small FIFO and shifts each
// one out as four 8N1 bytes (LSB byte first, LSB bit first), then idles for a gap.
module slave_transmit #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_LOG2    = 2,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          nonce,
  input  logic                 new_nonce,
  output logic                 TxD,
  output logic                 busy,
  output logic [FIFO_LOG2:0]   fifo_count,
  output logic [7:0]           dropped
);

  localparam int unsigned Depth     = 2 ** FIFO_LOG2;
  localparam int unsigned GapCycles = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned CntSpan   = (GapCycles > CLKS_PER_BIT) ? GapCycles : CLKS_PER_BIT;
  localparam int unsigned CntW      = (CntSpan > 1) ? $clog2(CntSpan) : 1;

  localparam logic [CntW-1:0]    BitLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]    GapLast = CntW'((GapCycles > 0) ? GapCycles - 1 : 0);
  localparam logic [FIFO_LOG2:0] Full    = (FIFO_LOG2 + 1)'(Depth);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StGap
  } state_e;

  state_e               state_q;
  logic [31:0]          mem [Depth];
  logic [FIFO_LOG2-1:0] rd_ptr_q;
  logic [FIFO_LOG2-1:0] wr_ptr_q;
  logic [31:0]          word_q;
  logic [1:0]           byte_q;
  logic [2:0]           bit_q;
  logic [2:0]           bit_nxt;
  logic [CntW-1:0]      cnt_q;
  logic                 pop;
  logic                 push;

  // A pop in IDLE frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted then.
  assign pop     = (state_q == StIdle) && (fifo_count != '0);
  assign push    = new_nonce && !reset && ((fifo_count != Full) || pop);
  assign bit_nxt = bit_q + 3'd1;
  assign busy    = (state_q != StIdle) || (fifo_count != '0);

  // FIFO storage, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= nonce;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_count <= '0;
      dropped    <= 8'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
      if (new_nonce && !push && (dropped != 8'hFF)) begin
        dropped <= dropped + 8'd1;
      end
    end
  end

  // Frame sequencer; TxD is registered and set together with each state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      TxD     <= 1'b1;
      word_q  <= '0;
      byte_q  <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          TxD <= 1'b1;
          if (pop) begin
            word_q  <= mem[rd_ptr_q];
            byte_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            TxD     <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            TxD     <= word_q[{byte_q, 3'd0}];
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              TxD     <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_q <= bit_nxt;
              TxD   <= word_q[{byte_q, bit_nxt}];
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (byte_q != 2'd3) begin
              byte_q  <= byte_q + 2'd1;
              TxD     <= 1'b0;
              state_q <= StStart;
            end else if (GAP_BITS == 0) begin
              state_q <= StIdle;
            end else begin
              state_q <= StGap;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          TxD     <= 1'b1;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_transmit.sv
// Testbench for slave_transmit: every cycle compares TxD, busy, fifo_count and
// dropped against a frame-level model built from the serial framing rules.
module tb_slave_transmit;

  localparam int unsigned Cpb   = 4;
  localparam int unsigned Log2  = 2;
  localparam int unsigned Gap   = 1;
  localparam int unsigned Depth = 2 ** Log2;

  logic          clk;
  logic          reset;
  logic [31:0]   nonce;
  logic          new_nonce;
  logic          TxD;
  logic          busy;
  logic [Log2:0] fifo_count;
  logic [7:0]    dropped;

  slave_transmit #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_LOG2    (Log2),
    .GAP_BITS     (Gap)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .nonce      (nonce),
    .new_nonce  (new_nonce),
    .TxD        (TxD),
    .busy       (busy),
    .fifo_count (fifo_count),
    .dropped    (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued words, expected line values for upcoming cycles.
  logic [31:0] fifo_m[$];
  bit          line_m[$];
  int          drop_m;
  bit          exp_tx;
  bit          exp_busy;
  int          tests;
  int          failed;
  int          peak;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      if (failed <= 20) $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line waveform of one word: 4x(start, 8 data LSB first, stop), gap, one idle cycle.
  task automatic build_frame(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      for (int c = 0; c < Cpb; c++) line_m.push_back(1'b0);
      for (int i = 0; i < 8; i++)
        for (int c = 0; c < Cpb; c++) line_m.push_back(w[b*8+i]);
      for (int c = 0; c < Cpb; c++) line_m.push_back(1'b1);
    end
    for (int c = 0; c < Gap * Cpb; c++) line_m.push_back(1'b1);
    line_m.push_back(1'b1);
  endtask

  task automatic model(input logic r, input logic nn, input logic [31:0] v);
    if (r) begin
      fifo_m.delete();
      line_m.delete();
      drop_m = 0;
      exp_tx = 1'b1;
    end else begin
      if (line_m.size() == 0 && fifo_m.size() > 0) build_frame(fifo_m.pop_front());
      if (nn) begin
        if (fifo_m.size() < Depth) fifo_m.push_back(v);
        else if (drop_m < 255) drop_m++;
      end
      exp_tx = (line_m.size() > 0) ? line_m.pop_front() : 1'b1;
    end
    exp_busy = (line_m.size() > 0) || (fifo_m.size() > 0);
  endtask

  task automatic step(input logic r, input logic nn, input logic [31:0] v);
    reset     = r;
    new_nonce = nn;
    nonce     = v;
    @(posedge clk);
    model(r, nn, v);
    #1;
    check_val("txd", TxD, exp_tx);
    check_val("busy", busy, exp_busy);
    check_val("fifo_count", fifo_count, fifo_m.size());
    check_val("dropped", dropped, drop_m);
    if (int'(fifo_count) > peak) peak = fifo_count;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    drop_m = 0;
    reset = 1'b1;
    new_nonce = 1'b0;
    nonce = '0;

    // Reset, with a push attempt that must be ignored.
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'hCAFEF00D);
    step(1'b1, 1'b0, 32'h0);
    check_val("reset_count", fifo_count, 0);

    // Single word.
    step(1'b0, 1'b1, 32'h12345678);
    idle(200);
    check_val("single_busy_after", busy, 0);

    // Five back-to-back pushes.
    peak = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'hA0000000 + i);
    idle(5 * 166 + 10);
    check_val("five_peak", peak, 4);
    check_val("five_dropped", dropped, 0);

    // Six pushes then sustained pushing: drops saturate, IDLE-cycle pushes accepted.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'hB0000000 + i);
    check_val("six_dropped", dropped, 1);
    for (int i = 0; i < 400; i++) step(1'b0, 1'b1, $urandom);
    check_val("dropped_sat", dropped, 255);
    idle(5 * 166 + 10);

    // Reset during data of byte 2, then a clean word.
    step(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hA5A5A5A5);
    step(1'b0, 1'b1, 32'h11111111);
    idle(95);
    step(1'b1, 1'b0, 32'h0);
    check_val("midrst_txd", TxD, 1);
    check_val("midrst_busy", busy, 0);
    check_val("midrst_count", fifo_count, 0);
    step(1'b0, 1'b1, 32'hDEADBEEF);
    idle(200);

    // Random traffic with occasional reset.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 1999) == 0), ($urandom_range(0, 99) < 3), $urandom);
    end
    idle(5 * 166 + 10);
    check_val("final_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
